// File: rtl/seq_mem_pkg.sv
// Types, default widths and a small helper shared by the sequential memory
// reader and writer.
package seq_mem_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 64;
  localparam int unsigned DEF_CNTR_WIDTH = 64;
  localparam int unsigned DEF_DATA_WIDTH = 64;
  localparam int unsigned DEF_ADDR_INC   = 4;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic                      last;
  } beat_t;

  // A beat is inconsistent when its last flag disagrees with its queue position.
  function automatic logic last_mismatch(input logic last, input logic last_entry);
    return last ^ last_entry;
  endfunction

endpackage

// File: rtl/seq_addr_gen.sv
// Queue bookkeeping for the sequential writer: base/length registers, entry
// counter, entry address and the last-entry flag.
module seq_addr_gen
  import seq_mem_pkg::*;
#(
  parameter int unsigned addr_width = DEF_ADDR_WIDTH,
  parameter int unsigned cntr_width = DEF_CNTR_WIDTH,
  parameter int unsigned addr_inc   = DEF_ADDR_INC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [addr_width-1:0] load_base,
  input  logic [cntr_width-1:0] load_len,
  output logic [addr_width-1:0] addr,
  output logic [cntr_width-1:0] cntr,
  output logic                  last_entry
);

  logic [addr_width-1:0] base_r;
  logic [cntr_width-1:0] len_r;
  logic [cntr_width-1:0] cntr_r;
  logic [cntr_width-1:0] cntr_inc_s;

  // Address product is truncated and the sum wraps at addr_width bits.
  always_comb begin
    cntr_inc_s = cntr_r + {{(cntr_width-1){1'b0}}, 1'b1};
    last_entry = (cntr_inc_s == len_r);
    addr       = base_r + (addr_width'(cntr_r) * addr_width'(addr_inc));
    cntr       = cntr_r;
  end

  // Loading a new queue takes priority over counting a completed write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_r <= {addr_width{1'b0}};
      len_r  <= {cntr_width{1'b0}};
      cntr_r <= {cntr_width{1'b0}};
    end else if (load) begin
      base_r <= load_base;
      len_r  <= load_len;
      cntr_r <= {cntr_width{1'b0}};
    end else if (step) begin
      cntr_r <= cntr_inc_s;
    end
  end

endmodule

// File: rtl/seq_mem_writer.sv
// Sequential memory writer: takes {data,last} beats over valid/ready and writes
// them to base + n*addr_inc with a request/response memory handshake.
module seq_mem_writer
  import seq_mem_pkg::*;
#(
  parameter int unsigned addr_width  = DEF_ADDR_WIDTH,
  parameter int unsigned cntr_width  = DEF_CNTR_WIDTH,
  parameter int unsigned data_width  = DEF_DATA_WIDTH,
  parameter int unsigned input_width = data_width + 1,
  parameter int unsigned addr_inc    = DEF_ADDR_INC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [input_width-1:0] data_i,
  input  logic [addr_width-1:0]  base_addr,
  input  logic [cntr_width-1:0]  queue_length,
  input  logic                   new_iteration,
  output logic                   mem_write,
  output logic [addr_width-1:0]  mem_addr,
  output logic [data_width-1:0]  mem_wdata,
  input  logic                   mem_resp,
  output logic                   done_o,
  output logic                   err_o,
  output logic [cntr_width-1:0]  count_o
);

  localparam logic [1:0] S_WAIT   = ST_WAIT;
  localparam logic [1:0] S_ACCEPT = ST_ACCEPT;
  localparam logic [1:0] S_WRITE  = ST_WRITE;
  localparam logic [1:0] S_DONE   = ST_DONE;

  logic [1:0]            state_r;
  logic [1:0]            state_nx;
  logic                  wlast_r;
  logic                  pend_r;
  logic [addr_width-1:0] pend_base_r;
  logic [cntr_width-1:0] pend_len_r;

  logic                  accept_s;
  logic                  resp_s;
  logic                  load_s;
  logic                  final_s;
  logic                  len_zero_s;
  logic                  done_nx;
  logic                  err_nx;
  logic [addr_width-1:0] load_base_s;
  logic [cntr_width-1:0] load_len_s;
  logic [addr_width-1:0] addr_s;
  logic                  last_entry_s;

  assign ready_o = (state_r == S_ACCEPT) & ~new_iteration;

  seq_addr_gen #(
    .addr_width (addr_width),
    .cntr_width (cntr_width),
    .addr_inc   (addr_inc)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .step       (resp_s),
    .load_base  (load_base_s),
    .load_len   (load_len_s),
    .addr       (addr_s),
    .cntr       (count_o),
    .last_entry (last_entry_s)
  );

  // A new_iteration coinciding with the in-flight response is applied directly.
  always_comb begin
    accept_s = ready_o & valid_i;
    resp_s   = (state_r == S_WRITE) & mem_write & mem_resp;
    final_s  = last_entry_s | wlast_r;
    if (new_iteration) begin
      load_base_s = base_addr;
      load_len_s  = queue_length;
    end else begin
      load_base_s = pend_base_r;
      load_len_s  = pend_len_r;
    end
    load_s     = (new_iteration & (state_r != S_WRITE)) | (resp_s & (pend_r | new_iteration));
    len_zero_s = (load_len_s == {cntr_width{1'b0}});
  end

  // Next state, done pulse and sticky error; a queue switch hides the old done.
  always_comb begin
    state_nx = state_r;
    done_nx  = 1'b0;
    err_nx   = err_o;
    if (load_s) begin
      state_nx = len_zero_s ? S_DONE : S_ACCEPT;
      done_nx  = len_zero_s;
      err_nx   = 1'b0;
    end else if (accept_s) begin
      state_nx = S_WRITE;
    end else if (resp_s) begin
      state_nx = final_s ? S_DONE : S_ACCEPT;
      done_nx  = final_s;
      err_nx   = err_o | last_mismatch(wlast_r, last_entry_s);
    end else begin
      state_nx = state_r;
    end
  end

  // FSM, status and memory request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_WAIT;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= {addr_width{1'b0}};
      mem_wdata <= {data_width{1'b0}};
      wlast_r   <= 1'b0;
    end else begin
      state_r <= state_nx;
      done_o  <= done_nx;
      err_o   <= err_nx;
      if (accept_s) begin
        mem_write <= 1'b1;
        mem_addr  <= addr_s;
        mem_wdata <= data_i[data_width:1];
        wlast_r   <= data_i[0];
      end else if (resp_s) begin
        mem_write <= 1'b0;
      end
    end
  end

  // Pending queue parameters captured while a write is outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_r      <= 1'b0;
      pend_base_r <= {addr_width{1'b0}};
      pend_len_r  <= {cntr_width{1'b0}};
    end else if (resp_s) begin
      pend_r <= 1'b0;
    end else if (new_iteration & (state_r == S_WRITE)) begin
      pend_r      <= 1'b1;
      pend_base_r <= base_addr;
      pend_len_r  <= queue_length;
    end
  end

endmodule

// File: doc/seq_mem_writer.md
Name: seq_mem_writer

Overview:
- Sequential memory writer; the write-direction counterpart of the sequential reader.
- Accepts a stream of data beats from the previous module over valid/ready, each beat with a last flag.
- Writes beats to consecutive addresses base_addr + n*addr_inc using a request/response memory handshake.
- Signals completion and protocol errors to the testbench/controller side.

Parameters:
- addr_width, 64, memory address width.
- cntr_width, 64, beat counter and queue_length width.
- data_width, 64, memory write data width.
- input_width, data_width+1, input beat width, packed as {data, last}.
- addr_inc, 4, byte stride between consecutive entries.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- valid_i  in  1  input beat valid from the previous module.
- ready_o  out  1  block can accept a beat.
- data_i  in  input_width  {data[data_width-1:0], last}.
- base_addr  in  addr_width  queue base address; sampled on new_iteration.
- queue_length  in  cntr_width  number of entries; sampled on new_iteration.
- new_iteration  in  1  single-cycle pulse that starts a new queue.
- mem_write  out  1  write request, held until mem_resp.
- mem_addr  out  addr_width  write address, registered.
- mem_wdata  out  data_width  write data, registered.
- mem_resp  in  1  memory write-complete strobe.
- done_o  out  1  one-cycle pulse when the queue completes.
- err_o  out  1  sticky last/length mismatch; cleared by new_iteration.
- count_o  out  cntr_width  entries written in the current queue.

Behaviour:
- States: S_WAIT (after reset, no queue configured), S_ACCEPT, S_WRITE, S_DONE.
- Reset (rst low, async): state S_WAIT. mem_write=0, mem_addr=0, mem_wdata=0, done_o=0, err_o=0, count_o=0, ready_o=0, all internal registers 0.
  - Reset mid-write drops the request immediately; any late mem_resp is ignored.
- new_iteration in S_WAIT, S_ACCEPT or S_DONE:
  - Latch base_addr and queue_length; clear cntr and err_o.
  - queue_length==0: go to S_DONE and pulse done_o the next cycle.
  - Otherwise go to S_ACCEPT.
- new_iteration in S_WRITE: latch the new parameters into a pending slot and set pend.
  - The in-flight write still completes.
  - On its mem_resp, apply the pending parameters (same rules as above), clear pend, and suppress done_o for the old queue.
- ready_o = (state==S_ACCEPT) & ~new_iteration. ready_o is 0 in S_WAIT, S_WRITE and S_DONE.
- Accept (S_ACCEPT & valid_i & ready_o) at edge k:
  - mem_wdata<=data; mem_addr<=base+cntr*addr_inc; mem_write<=1; state S_WRITE.
  - mem_write is visible in the cycle after edge k.
- S_WRITE: hold mem_write, mem_addr and mem_wdata stable until mem_resp. On mem_resp:
  - mem_write<=0; cntr<=cntr+1.
  - final = (cntr+1==queue_length) | last.
  - final: go to S_DONE and pulse done_o one cycle.
  - Not final: return to S_ACCEPT; the earliest next accept is the following cycle, so throughput is at most 1 beat per 2 cycles plus memory latency.
- err_o is set when last=1 with cntr+1<queue_length (early termination, still goes to S_DONE), or when cntr+1==queue_length with last=0.
- mem_resp while mem_write=0 is ignored.
- Address arithmetic: product truncated to addr_width; the sum wraps modulo 2^addr_width.
- count_o = cntr. cntr never exceeds queue_length.
- S_DONE holds with ready_o=0 until new_iteration; extra input beats are back-pressured, never dropped.

Decomposition:
- Shared package seq_mem_pkg:
  - State enum typedef.
  - Default width localparams.
  - A beat struct typedef {data, last}, which the sequential reader can reuse.
- One sub-module, seq_addr_gen: registered base/length, counter, address = base + cntr*addr_inc, final flag.
  - The FSM and the data register stay in seq_mem_writer.

Test Plan:
- Queue of 3 entries: base=0x1000, len=3, beats D0..D2 with last on D2, mem_resp 2 cycles after each request. Required: writes to 0x1000, 0x1004, 0x1008 with matching data; done_o pulses once; count_o=3; err_o=0.
- Back-pressure: valid_i held high with mem_resp delayed 5 cycles. Required: ready_o=0 throughout S_WRITE; mem_addr and mem_wdata stable; no beat lost or duplicated.
- Early last: len=4 with last on beat 2. Required: 2 writes, then done_o, err_o=1, count_o=2. A subsequent new_iteration clears err_o.
- Zero-length queue: len=0 with new_iteration. Required: no mem_write, done_o pulse one cycle later, ready_o stays 0.
- new_iteration during S_WRITE with new base=0x2000, len=1. Required: the in-flight write completes; the next accepted beat is written to 0x2000; no done_o for the old queue.
- Async reset asserted mid-write (between clock edges). Required: mem_write drops to 0 immediately; after release the block is in S_WAIT with ready_o=0 and count_o=0, and a stray mem_resp is ignored.
